// File: rtl/prog_loader.sv
// Boot-time program loader: streams host words into IMem over valid/ready, holds the
// processor in reset through load and flush, then runs it until halt and reports counts.
module prog_loader #(
  parameter int WIDTH     = 32,
  parameter int ADDR_W    = 10,
  parameter int FLUSH_CYC = 4,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_last,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [WIDTH-1:0]  imem_wr_data,
  output logic              proc_rst_n,
  input  logic              halt,
  output logic              done,
  output logic              err_overflow,
  output logic [ADDR_W:0]   words_loaded,
  output logic [CNT_W-1:0]  run_cycles
);

  localparam int WL_W = ADDR_W + 1;
  localparam int FC_W = (FLUSH_CYC < 1) ? 1 : $clog2(FLUSH_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_RUN,
    S_HALTED,
    S_ERROR
  } state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic [FC_W-1:0]   flush_cnt, flush_cnt_d;

  logic              in_ready_d;
  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [WIDTH-1:0]  wr_data_d;
  logic              proc_rst_n_d;
  logic              done_d;
  logic              err_d;
  logic [ADDR_W:0]   words_d;
  logic [CNT_W-1:0]  run_d;
  logic              accept;

  // Cycle counter sticks at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign accept = in_valid & in_ready;

  always_comb begin
    state_d     = state;
    addr_d      = addr;
    flush_cnt_d = flush_cnt;
    wr_en_d     = 1'b0;
    wr_addr_d   = imem_wr_addr;
    wr_data_d   = imem_wr_data;
    words_d     = words_loaded;
    run_d       = run_cycles;

    case (state)
      S_IDLE, S_HALTED, S_ERROR: begin
        if (start) begin
          state_d = S_LOAD;
          addr_d  = '0;
          words_d = '0;
          run_d   = '0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr;
          wr_data_d = in_data;
          addr_d    = addr + ADDR_W'(1);
          words_d   = words_loaded + WL_W'(1);
          if (in_last) begin
            state_d     = S_FLUSH;
            flush_cnt_d = FC_W'(FLUSH_CYC);
          end else if (&addr) begin
            // Last slot was just filled but the program keeps going.
            state_d = S_ERROR;
          end
        end
      end
      S_FLUSH: begin
        if (flush_cnt == '0) state_d = S_RUN;
        else                 flush_cnt_d = flush_cnt - FC_W'(1);
      end
      S_RUN: begin
        if (halt) state_d = S_HALTED;
        else      run_d   = sat_inc(run_cycles);
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are a registered function of the state being entered.
    in_ready_d   = (state_d == S_LOAD);
    proc_rst_n_d = (state_d == S_RUN) || (state_d == S_HALTED);
    done_d       = (state_d == S_HALTED);
    err_d        = (state_d == S_ERROR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      addr         <= '0;
      flush_cnt    <= '0;
      in_ready     <= 1'b0;
      imem_wr_en   <= 1'b0;
      imem_wr_addr <= '0;
      imem_wr_data <= '0;
      proc_rst_n   <= 1'b0;
      done         <= 1'b0;
      err_overflow <= 1'b0;
      words_loaded <= '0;
      run_cycles   <= '0;
    end else begin
      state        <= state_d;
      addr         <= addr_d;
      flush_cnt    <= flush_cnt_d;
      in_ready     <= in_ready_d;
      imem_wr_en   <= wr_en_d;
      imem_wr_addr <= wr_addr_d;
      imem_wr_data <= wr_data_d;
      proc_rst_n   <= proc_rst_n_d;
      done         <= done_d;
      err_overflow <= err_d;
      words_loaded <= words_d;
      run_cycles   <= run_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a small mode-level model checked every cycle, plus directed
// scenarios with hand-computed expectations for writes, release timing, overflow and reset.
module tb_prog_loader;

  localparam int WIDTH     = 32;
  localparam int ADDR_W    = 3;
  localparam int FLUSH_CYC = 4;
  localparam int CNT_W     = 4;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int RUN_MAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              halt = 1'b0;
  logic [WIDTH-1:0]  in_data = '0;
  logic              in_ready;
  logic              imem_wr_en;
  logic [ADDR_W-1:0] imem_wr_addr;
  logic [WIDTH-1:0]  imem_wr_data;
  logic              proc_rst_n;
  logic              done;
  logic              err_overflow;
  logic [ADDR_W:0]   words_loaded;
  logic [CNT_W-1:0]  run_cycles;

  prog_loader #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr), .imem_wr_data(imem_wr_data),
    .proc_rst_n(proc_rst_n), .halt(halt), .done(done), .err_overflow(err_overflow),
    .words_loaded(words_loaded), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Mode-level model: which phase the loader is in, plus plain integer counts.
  typedef enum int {M_IDLE, M_LOAD, M_FLUSH, M_RUN, M_HALTED, M_ERROR} mode_t;
  mode_t            m_mode;
  int               m_addr, m_words, m_run, m_fl, m_wr_addr;
  bit               m_wr;
  logic [WIDTH-1:0] m_wr_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode  <= M_IDLE;
      m_addr  <= 0;
      m_words <= 0;
      m_run   <= 0;
      m_fl    <= 0;
      m_wr    <= 1'b0;
    end else begin
      m_wr <= 1'b0;
      case (m_mode)
        M_IDLE, M_HALTED, M_ERROR:
          if (start) begin
            m_mode  <= M_LOAD;
            m_addr  <= 0;
            m_words <= 0;
            m_run   <= 0;
          end
        M_LOAD:
          if (in_valid) begin
            m_wr      <= 1'b1;
            m_wr_addr <= m_addr;
            m_wr_data <= in_data;
            m_addr    <= m_addr + 1;
            m_words   <= m_words + 1;
            if (in_last) begin
              m_mode <= M_FLUSH;
              m_fl   <= 0;
            end else if (m_addr == DEPTH - 1) begin
              m_mode <= M_ERROR;
            end
          end
        M_FLUSH:
          if (m_fl == FLUSH_CYC) m_mode <= M_RUN;
          else                   m_fl   <= m_fl + 1;
        M_RUN:
          if (halt) m_mode <= M_HALTED;
          else if (m_run < RUN_MAX) m_run <= m_run + 1;
        default: ;
      endcase
    end
  end

  int               cyc = 0;
  int               rise_cyc = -1;
  logic             prev_prst = 1'b0;
  int               wr_addr_q[$];
  logic [WIDTH-1:0] wr_data_q[$];
  int               wr_cyc_q[$];

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      chk("in_ready", 64'(in_ready), 64'(m_mode == M_LOAD));
      chk("proc_rst_n", 64'(proc_rst_n), 64'(m_mode == M_RUN || m_mode == M_HALTED));
      chk("done", 64'(done), 64'(m_mode == M_HALTED));
      chk("err_overflow", 64'(err_overflow), 64'(m_mode == M_ERROR));
      chk("imem_wr_en", 64'(imem_wr_en), 64'(m_wr));
      if (m_wr) begin
        chk("imem_wr_addr", 64'(imem_wr_addr), 64'(m_wr_addr));
        chk("imem_wr_data", 64'(imem_wr_data), 64'(m_wr_data));
      end
      chk("words_loaded", 64'(words_loaded), 64'(m_words));
      chk("run_cycles", 64'(run_cycles), 64'(m_run));
      if (imem_wr_en) begin
        wr_addr_q.push_back(int'(imem_wr_addr));
        wr_data_q.push_back(imem_wr_data);
        wr_cyc_q.push_back(cyc);
      end
      if (proc_rst_n && !prev_prst) rise_cyc = cyc;
      prev_prst = proc_rst_n;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic l);
    in_valid = v;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_release(input string name);
    int n = 0;
    while (!proc_rst_n && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(proc_rst_n), 64'd1);
  endtask

  initial begin
    int base;
    int c_write_cyc;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_proc_rst_n", 64'(proc_rst_n), 64'd0);
    chk("rst_words", 64'(words_loaded), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'd0);

    // 1: three back-to-back words, release FLUSH_CYC+1 cycles after last write
    base = wr_addr_q.size();
    pulse_start();
    drive(1'b1, 32'h1111_AAAA, 1'b0);
    drive(1'b1, 32'h2222_BBBB, 1'b0);
    drive(1'b1, 32'h3333_CCCC, 1'b1);
    idle_inputs();
    wait_release("t1_release");

    // 5: halt 10 cycles after release
    repeat (10) @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    chk("t5_run_cycles", 64'(run_cycles), 64'd10);
    chk("t5_done", 64'(done), 64'd1);
    chk("t5_proc_rst_n", 64'(proc_rst_n), 64'd1);

    chk("t1_nwrites", 64'(wr_addr_q.size() - base), 64'd3);
    chk("t1_addr0", 64'(wr_addr_q[base]), 64'd0);
    chk("t1_data0", 64'(wr_data_q[base]), 64'h1111_AAAA);
    chk("t1_addr1", 64'(wr_addr_q[base+1]), 64'd1);
    chk("t1_data1", 64'(wr_data_q[base+1]), 64'h2222_BBBB);
    chk("t1_addr2", 64'(wr_addr_q[base+2]), 64'd2);
    chk("t1_data2", 64'(wr_data_q[base+2]), 64'h3333_CCCC);
    chk("t1_consecutive", 64'(wr_cyc_q[base+2] - wr_cyc_q[base]), 64'd2);
    c_write_cyc = wr_cyc_q[base+2];
    chk("t1_release_delay", 64'(rise_cyc - c_write_cyc), 64'(FLUSH_CYC + 1));
    chk("t1_words", 64'(words_loaded), 64'd3);

    // halt outside RUN has no effect
    halt = 1'b1;
    repeat (2) @(negedge clk);
    halt = 1'b0;
    chk("halted_hold_done", 64'(done), 64'd1);
    chk("halted_hold_run", 64'(run_cycles), 64'd10);

    // restart from HALTED clears everything on the next cycle
    pulse_start();
    chk("t5_restart_prst", 64'(proc_rst_n), 64'd0);
    chk("t5_restart_done", 64'(done), 64'd0);
    chk("t5_restart_run", 64'(run_cycles), 64'd0);
    chk("t5_restart_words", 64'(words_loaded), 64'd0);

    // 2: valid toggling, dangling in_last without valid ignored
    base = wr_addr_q.size();
    drive(1'b1, 32'h0000_0D01, 1'b0);
    drive(1'b0, 32'hDEAD_BEEF, 1'b1);
    drive(1'b1, 32'h0000_0D02, 1'b1);
    drive(1'b0, 32'hDEAD_BEEF, 1'b0);
    idle_inputs();
    @(negedge clk);
    chk("t2_nwrites", 64'(wr_addr_q.size() - base), 64'd2);
    chk("t2_addr0", 64'(wr_addr_q[base]), 64'd0);
    chk("t2_addr1", 64'(wr_addr_q[base+1]), 64'd1);
    chk("t2_data1", 64'(wr_data_q[base+1]), 64'h0000_0D02);
    chk("t2_words", 64'(words_loaded), 64'd2);
    wait_release("t2_release");
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;

    // 3: nine words without last overflow an 8-word IMem
    base = wr_addr_q.size();
    pulse_start();
    for (int i = 0; i < 9; i++) drive(1'b1, 32'hA000_0000 + 32'(i), 1'b0);
    idle_inputs();
    @(negedge clk);
    chk("t3_nwrites", 64'(wr_addr_q.size() - base), 64'd8);
    chk("t3_last_addr", 64'(wr_addr_q[base+7]), 64'd7);
    chk("t3_last_data", 64'(wr_data_q[base+7]), 64'hA000_0007);
    chk("t3_err", 64'(err_overflow), 64'd1);
    chk("t3_in_ready", 64'(in_ready), 64'd0);
    chk("t3_prst", 64'(proc_rst_n), 64'd0);
    chk("t3_words", 64'(words_loaded), 64'd8);

    // 4: exactly full-capacity program is not an error
    base = wr_addr_q.size();
    pulse_start();
    chk("t4_err_cleared", 64'(err_overflow), 64'd0);
    for (int i = 0; i < 8; i++) drive(1'b1, 32'hB000_0000 + 32'(i), 1'b1 ? (i == 7) : 1'b0);
    idle_inputs();
    @(negedge clk);
    chk("t4_nwrites", 64'(wr_addr_q.size() - base), 64'd8);
    chk("t4_words", 64'(words_loaded), 64'd8);
    chk("t4_err", 64'(err_overflow), 64'd0);
    wait_release("t4_release");

    // run_cycles saturates at all-ones
    repeat (20) @(negedge clk);
    chk("sat_run_cycles", 64'(run_cycles), 64'(RUN_MAX));

    // start together with halt in RUN: halt wins, start is lost
    start = 1'b1;
    halt  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    halt  = 1'b0;
    @(negedge clk);
    chk("sh_done", 64'(done), 64'd1);
    chk("sh_prst", 64'(proc_rst_n), 64'd1);
    chk("sh_in_ready", 64'(in_ready), 64'd0);

    // 6: asynchronous reset while loading at addr 2
    base = wr_addr_q.size();
    pulse_start();
    drive(1'b1, 32'hC000_0000, 1'b0);
    drive(1'b1, 32'hC000_0001, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'hC000_0002;
    #2 rst = 1'b1;
    #1;
    chk("t6_in_ready", 64'(in_ready), 64'd0);
    chk("t6_wr_en", 64'(imem_wr_en), 64'd0);
    chk("t6_wr_addr", 64'(imem_wr_addr), 64'd0);
    chk("t6_wr_data", 64'(imem_wr_data), 64'd0);
    chk("t6_prst", 64'(proc_rst_n), 64'd0);
    chk("t6_done", 64'(done), 64'd0);
    chk("t6_err", 64'(err_overflow), 64'd0);
    chk("t6_words", 64'(words_loaded), 64'd0);
    chk("t6_run", 64'(run_cycles), 64'd0);
    repeat (2) @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_nwrites", 64'(wr_addr_q.size() - base), 64'd2);
    pulse_start();
    drive(1'b1, 32'hC0DE_0000, 1'b1);
    idle_inputs();
    repeat (2) @(negedge clk);
    chk("t6_restart_n", 64'(wr_addr_q.size() - base), 64'd3);
    chk("t6_restart_addr", 64'(wr_addr_q[base+2]), 64'd0);
    chk("t6_restart_data", 64'(wr_data_q[base+2]), 64'hC0DE_0000);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
